psum_accumulator: RTL and testbench

//   Clocked stage directly downstream of the PE adder. Accumulates NUM_TERMS partial sums per output neuron

---
 rtl/psum_pkg.sv | 23 ++
 rtl/psum_sat_add.sv | 22 ++
 rtl/psum_accumulator.sv | 120 ++++++++++++
 tb/tb_psum_accumulator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared types, widths and saturating-add helper for the PE/psum stages
package psum_pkg;

    localparam int PSUM_DWIDTH = 8;
    localparam int PSUM_AWIDTH = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } psum_state_e;

    // Unsigned add clamped to 2^width-1; operands must already fit in width bits (width <= 32)
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] cap;
        sum = {1'b0, a} + {1'b0, b};
        cap = (33'd1 << width) - 33'd1;
        return (sum > cap) ? cap[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// rtl/psum_sat_add.sv - combinational AWIDTH-wide unsigned saturating adder
module psum_sat_add
    import psum_pkg::*;
#(
    parameter int AWIDTH = PSUM_AWIDTH
) (
    input  logic [AWIDTH-1:0] a,
    input  logic [AWIDTH-1:0] b,
    output logic [AWIDTH-1:0] sum
);

    logic [31:0] full;

    // Saturating sum via the shared helper, evaluated at 32 bits
    always_comb begin
        full = sat_add(32'(a), 32'(b), int'(AWIDTH));
    end

    // Bits above AWIDTH are zero by construction; folding them in keeps every helper bit live
    assign sum = full[AWIDTH-1:0] | {AWIDTH{|(full >> AWIDTH)}};

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates NUM_TERMS partial sums into a potential and emits potential + spike
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int DWIDTH    = PSUM_DWIDTH,
    parameter int AWIDTH    = PSUM_AWIDTH,
    parameter int NUM_TERMS = 5,
    parameter int THRESHOLD = 64,
    parameter int RESIDUAL  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pot_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] out_potential,
    output logic              out_spike
);

    localparam int              CW       = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(NUM_TERMS - 1);
    localparam logic [AWIDTH-1:0] THRESH = AWIDTH'(THRESHOLD);

    psum_state_e       state_q, state_d;
    logic [AWIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AWIDTH-1:0] pot_q, pot_d;
    logic              spike_q, spike_d;
    logic              clr_pend_q, clr_pend_d;

    logic [AWIDTH-1:0] acc_base;
    logic [AWIDTH-1:0] acc_sum;
    logic [CW-1:0]     cnt_base;

    // A same-cycle clear makes the incoming term the first of a fresh group
    assign acc_base = pot_clr ? '0 : acc_q;
    assign cnt_base = pot_clr ? '0 : cnt_q;

    psum_sat_add #(
        .AWIDTH (AWIDTH)
    ) u_sat_add (
        .a   (acc_base),
        .b   (AWIDTH'(in_data)),
        .sum (acc_sum)
    );

    assign in_ready      = rst_n && (state_q == ACCUM);
    assign out_valid     = (state_q == EMIT);
    assign out_potential = pot_q;
    assign out_spike     = spike_q;

    // Next-state: accumulate terms, latch the result on the last term, apply residual on output transfer
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        pot_d      = pot_q;
        spike_d    = spike_q;
        clr_pend_d = clr_pend_q;
        case (state_q)
            ACCUM: begin
                if (pot_clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                end
                if (in_valid) begin
                    acc_d = acc_sum;
                    if (cnt_base == LAST_CNT) begin
                        cnt_d   = '0;
                        pot_d   = acc_sum;
                        spike_d = (acc_sum >= THRESH);
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_base + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (pot_clr) begin
                    clr_pend_d = 1'b1;
                end
                if (out_ready) begin
                    state_d    = ACCUM;
                    clr_pend_d = 1'b0;
                    if (clr_pend_q || pot_clr || (RESIDUAL == 0)) begin
                        acc_d = '0;
                    end else if (spike_q) begin
                        acc_d = pot_q - THRESH;
                    end else begin
                        acc_d = pot_q;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            pot_q      <= '0;
            spike_q    <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            pot_q      <= pot_d;
            spike_q    <= spike_d;
            clr_pend_q <= clr_pend_d;
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - scoreboard bench for psum_accumulator (default, AWIDTH=10, NUM_TERMS=1/RESIDUAL=0)
module tb_psum_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid [3];
    logic [7:0] in_data  [3];
    logic       pot_clr  [3];
    logic       out_ready[3];

    bit rnd_bit [3];
    bit rnd_mode[3];
    bit hold    [3];

    logic        a_rdy, a_ov, a_sp;
    logic [15:0] a_pot;
    logic        b_rdy, b_ov, b_sp;
    logic [9:0]  b_pot;
    logic        c_rdy, c_ov, c_sp;
    logic [15:0] c_pot;

    logic        rdy [3];
    logic        ov  [3];
    logic        osp [3];
    logic [15:0] opot[3];

    int checks = 0;
    int errors = 0;

    int unsigned exp_q[3][$];
    int unsigned m_pot[3];
    int unsigned m_cnt[3];

    always #5 clk = ~clk;

    psum_accumulator u_dut_a (
        .clk (clk), .rst_n (rst_n), .pot_clr (pot_clr[0]),
        .in_valid (in_valid[0]), .in_ready (a_rdy), .in_data (in_data[0]),
        .out_valid (a_ov), .out_ready (out_ready[0]), .out_potential (a_pot), .out_spike (a_sp)
    );

    psum_accumulator #(.AWIDTH(10)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .pot_clr (pot_clr[1]),
        .in_valid (in_valid[1]), .in_ready (b_rdy), .in_data (in_data[1]),
        .out_valid (b_ov), .out_ready (out_ready[1]), .out_potential (b_pot), .out_spike (b_sp)
    );

    psum_accumulator #(.NUM_TERMS(1), .RESIDUAL(0)) u_dut_c (
        .clk (clk), .rst_n (rst_n), .pot_clr (pot_clr[2]),
        .in_valid (in_valid[2]), .in_ready (c_rdy), .in_data (in_data[2]),
        .out_valid (c_ov), .out_ready (out_ready[2]), .out_potential (c_pot), .out_spike (c_sp)
    );

    always_comb begin
        rdy[0] = a_rdy; ov[0] = a_ov; osp[0] = a_sp; opot[0] = a_pot;
        rdy[1] = b_rdy; ov[1] = b_ov; osp[1] = b_sp; opot[1] = {6'b0, b_pot};
        rdy[2] = c_rdy; ov[2] = c_ov; osp[2] = c_sp; opot[2] = c_pot;
        for (int d = 0; d < 3; d++) begin
            out_ready[d] = rnd_mode[d] ? rnd_bit[d] : hold[d];
        end
    end

    always begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rnd_bit[d] = 1'($urandom_range(0, 1));
    end

    function automatic int unsigned maxv(input int d);
        return (d == 1) ? 1023 : 65535;
    endfunction

    function automatic int unsigned nterms(input int d);
        return (d == 2) ? 1 : 5;
    endfunction

    function automatic bit resid(input int d);
        return (d == 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic void model_in(input int d, input int unsigned v);
        int unsigned s;
        bit sp;
        s = m_pot[d] + v;
        if (s > maxv(d)) s = maxv(d);
        m_pot[d] = s;
        m_cnt[d]++;
        if (m_cnt[d] == nterms(d)) begin
            sp = (s >= 64);
            exp_q[d].push_back(s * 2 + int'(sp));
            m_cnt[d] = 0;
            m_pot[d] = resid(d) ? (sp ? s - 64 : s) : 0;
        end
    endfunction

    function automatic void model_clr(input int d);
        m_pot[d] = 0;
        m_cnt[d] = 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int unsigned e;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && out_ready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut%0d_unexpected_output actual=%0d expected=none", d, opot[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        chk($sformatf("dut%0d_out_potential", d), opot[d], e >> 1);
                        chk($sformatf("dut%0d_out_spike", d), osp[d], e & 1);
                    end
                end
            end
        end
    end

    task automatic send(input int d, input int unsigned v, input bit clr);
        int n;
        n = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = 8'(v);
        @(negedge clk);
        while (!rdy[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_send_timeout actual=not_ready expected=ready", d);
            in_valid[d] = 1'b0;
            return;
        end
        if (clr) pot_clr[d] = 1'b1;
        @(posedge clk);
        if (clr) model_clr(d);
        model_in(d, v);
        #1;
        in_valid[d] = 1'b0;
        pot_clr[d]  = 1'b0;
    endtask

    task automatic gap(input int mx);
        repeat ($urandom_range(0, mx)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (exp_q[d].size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk($sformatf("dut%0d_drain", d), exp_q[d].size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int unsigned t1[10] = '{10, 20, 5, 15, 30, 1, 1, 1, 1, 1};
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0;
            in_data[d]  = 8'd0;
            pot_clr[d]  = 1'b0;
            hold[d]     = 1'b1;
            rnd_mode[d] = 1'b0;
            m_pot[d]    = 0;
            m_cnt[d]    = 0;
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", a_ov, 0);
        chk("reset_out_potential", a_pot, 0);
        chk("reset_out_spike", a_sp, 0);
        chk("reset_in_ready", a_rdy, 0);
        chk("reset_in_ready_b", b_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", a_rdy, 1);

        // two groups: 80/spike then 21 with residual
        foreach (t1[i]) send(0, t1[i], 1'b0);
        wait_drain(0);

        // back-pressure in EMIT with a pending input
        hold[0] = 1'b0;
        repeat (5) send(0, 4, 1'b0);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'd7;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_out_valid", ov[0], 1);
            chk("hold_in_ready", rdy[0], 0);
            if (exp_q[0].size() != 0) chk("hold_out_potential", opot[0], exp_q[0][0] >> 1);
        end
        @(posedge clk);
        #1;
        hold[0] = 1'b1;
        send(0, 7, 1'b0);
        repeat (4) send(0, 1, 1'b0);
        wait_drain(0);

        // clear while a result is pending
        hold[0] = 1'b0;
        repeat (5) send(0, 30, 1'b0);
        @(negedge clk);
        pot_clr[0] = 1'b1;
        @(posedge clk);
        m_pot[0] = 0;
        #1;
        pot_clr[0] = 1'b0;
        hold[0]    = 1'b1;
        repeat (5) send(0, 1, 1'b0);
        wait_drain(0);

        // clear mid-group
        send(0, 50, 1'b0);
        send(0, 50, 1'b0);
        @(negedge clk);
        pot_clr[0] = 1'b1;
        @(posedge clk);
        model_clr(0);
        #1;
        pot_clr[0] = 1'b0;
        repeat (5) send(0, 3, 1'b0);
        wait_drain(0);

        // async reset mid-group
        repeat (3) send(0, 40, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", a_ov, 0);
        chk("async_reset_out_potential", a_pot, 0);
        chk("async_reset_out_spike", a_sp, 0);
        chk("async_reset_in_ready", a_rdy, 0);
        for (int d = 0; d < 3; d++) begin
            model_clr(d);
            exp_q[d].delete();
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) send(0, 2, 1'b0);
        wait_drain(0);

        // randomized traffic with gaps, back-pressure and same-cycle clears
        rnd_mode[0] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            send(0, $urandom_range(0, 255), ($urandom_range(0, 7) == 0));
            gap(2);
        end
        wait_drain(0);
        rnd_mode[0] = 1'b0;

        // narrow accumulator saturation and residual from the saturated value
        repeat (5) send(1, 255, 1'b0);
        repeat (5) send(1, 0, 1'b0);
        rnd_mode[1] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            send(1, $urandom_range(150, 255), 1'b0);
            gap(1);
        end
        wait_drain(1);

        // single-term groups, no residual, random gaps on both sides
        rnd_mode[2] = 1'b1;
        gap(3);
        send(2, 70, 1'b0);
        gap(3);
        send(2, 3, 1'b0);
        for (int k = 0; k < 30; k++) begin
            gap(3);
            send(2, $urandom_range(0, 255), 1'b0);
        end
        wait_drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
